lrc_line_sched: RTL and testbench
=================================

Name: lrc_line_sched

Overview:
- Sequences the two 512x16 left/right disparity line SRAMs that feed the left-right-check datapath.
- FILL phase: writes one row of left and right disparities, whose streams may be misaligned.
- DRAIN phase: for every column x, reads L[x], then R[x - int(L[x])], and presents an aligned pair to the LRC compare logic.
- Sits between the SGM aggregation output and the post-processing LRC/hole-fill stage; throttles upstream with in_ready.

Parameters:
DWIDTH, 16, disparity word width
FRAC, 4, fractional bits in a disparity word; integer disparity = disp[DWIDTH-1:FRAC]
AWIDTH, 9, SRAM address width (depth 512)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low (0 = reset)
enable  in  1  block enable; 0 forces IDLE at next edge
width  in  11  row width, sampled on entry to FILL; legal range 1..512
range  in  9  disparity search range; int disparity >= range marks invalid
valid_final_L  in  1  left disparity strobe
valid_final_R  in  1  right disparity strobe
disp_L  in  DWIDTH  left disparity
disp_R  in  DWIDTH  right disparity
in_ready  out  1  1 = pixels accepted
wr_addr_lrc_L  out  AWIDTH  left SRAM write address
wr_addr_lrc_R  out  AWIDTH  right SRAM write address
wr_en_lrc_L  out  1  left write enable, active-low
wr_en_lrc_R  out  1  right write enable, active-low
rd_addr_lrc_L  out  AWIDTH  left SRAM read address
rd_addr_lrc_R  out  AWIDTH  right SRAM read address
q_L  in  DWIDTH  left SRAM read data, 1-cycle latency
q_R  in  DWIDTH  right SRAM read data, 1-cycle latency
chk_valid  out  1  aligned pair valid
chk_col  out  AWIDTH  column x of the pair
chk_disp_L  out  DWIDTH  L[x]
chk_disp_R  out  DWIDTH  R[x - int(L[x])]
chk_oob  out  1  x - int(L[x]) < 0, or int(L[x]) >= range
row_done  out  1  one-cycle pulse after the last pair
err_width  out  1  sticky; illegal width seen
err_ovf  out  1  sticky; strobe received while in_ready = 0

Behaviour:
- Reset (rst = 0): state IDLE, all counters 0, all outputs 0 except wr_en_lrc_L/R = 1 (inactive).
- IDLE:
  - enable = 1 and width in 1..512: latch width -> W, go to FILL, in_ready = 1.
  - Illegal width: set err_width, stay IDLE.
- FILL:
  - Independent column counters cL and cR.
  - valid_final_L: wr_addr_lrc_L = cL, wr_en_lrc_L = 0 in the same cycle as the strobe (combinational from the registered counter); then cL++.
  - valid_final_R: same, using cR.
  - Strobes beyond W on a side are dropped and set err_ovf.
  - When both counters have reached W (including the case where both complete in the same cycle): in_ready = 0 from the next cycle, go to DRAIN.
- DRAIN: 3-stage pipeline, one column per cycle, no bubbles.
  - S0: rd_addr_lrc_L = x; x runs 0..W-1.
  - S1: d = q_L[DWIDTH-1:FRAC]; t = x - d, computed signed at AWIDTH+1 bits.
    - If t < 0 or d >= range: oob = 1 and rd_addr_lrc_R = 0.
    - Else rd_addr_lrc_R = t.
    - Register q_L, x and oob.
  - S2: chk_valid = 1; chk_disp_R = q_R; chk_disp_L, chk_col and chk_oob come from the S1 registers.
  - Latency: rd_addr_lrc_L issue to chk_valid = 2 cycles.
  - Exactly W chk_valid pulses per row.
  - row_done asserts in the cycle after the last chk_valid; state returns to IDLE.
- IDLE re-entry: with enable still 1, FILL restarts the next cycle. Minimum turnaround is 1 IDLE cycle.
- Strobes in IDLE or DRAIN are dropped and set err_ovf.
- enable deasserted mid-row: go to IDLE on the next edge; pipeline is flushed; chk_valid/row_done are not emitted; error flags are kept.
- Reset mid-operation: immediate return to reset values. Error flags clear only on reset.
- Read enable to the SRAM is tied inactive-writes (port B write disabled); no rd_en output is needed.

Decomposition:
- Shared package lrc_pkg:
  - state enum {IDLE, FILL, DRAIN}
  - DEPTH = 512, FRAC, AWIDTH constants
  - function disp_int()
- One natural sub-module, lrc_drain_pipe: the S0–S2 address/alignment pipeline with its own x counter. FSM, fill counters and error logic stay in the top.

Test Plan:
- W = 4, L/R aligned, L = {0,1,2,3} integer (<<FRAC), R = {10,11,12,13}, range = 64 -> wr addrs 0..3 both sides; chk_col 0..3 with chk_disp_R = {10,10,10,10}, chk_oob = 0; row_done 1 cycle after the 4th chk_valid.
- W = 3, R stream lags L by 5 cycles -> DRAIN starts only after the 3rd R write; in_ready falls 1 cycle later; 3 pairs emitted.
- W = 4, L = {2,0,5,1}, range = 4 -> col0 oob (t = -2), col2 oob (5 >= range), col1/col3 valid reading R addr 1 and 2.
- Strobe during DRAIN -> err_ovf = 1, no SRAM write, pair output unchanged; width = 0 or 600 -> err_width = 1, FSM stays IDLE.
- W = 512 full depth -> addresses reach 511 with no wrap; exactly 512 chk_valid.
- rst = 0 asserted mid-DRAIN at column 7 -> all outputs return to reset values asynchronously; next row after release restarts from column 0.

Source files
------------

// File: rtl/lrc_pkg.sv
// Shared types and constants for the left-right-check line scheduler.
package lrc_pkg;

  localparam int DWIDTH = 16;
  localparam int FRAC   = 4;
  localparam int AWIDTH = 9;
  localparam int DEPTH  = 512;
  localparam int IWIDTH = DWIDTH - FRAC;
  // Column counters need one extra bit so they can hold DEPTH itself.
  localparam int CWIDTH = AWIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  function automatic logic [IWIDTH-1:0] disp_int(input logic [DWIDTH-1:0] disp);
    return IWIDTH'(disp >> FRAC);
  endfunction

endpackage

// File: rtl/lrc_line_sched_if.sv
// Pixel stream in (SGM side) and aligned pair stream out (LRC side).
interface lrc_line_sched_if;
  import lrc_pkg::*;

  logic              valid_final_L;
  logic              valid_final_R;
  logic [DWIDTH-1:0] disp_L;
  logic [DWIDTH-1:0] disp_R;
  logic              in_ready;

  logic              chk_valid;
  logic [AWIDTH-1:0] chk_col;
  logic [DWIDTH-1:0] chk_disp_L;
  logic [DWIDTH-1:0] chk_disp_R;
  logic              chk_oob;
  logic              row_done;

  modport master (
    output valid_final_L, valid_final_R, disp_L, disp_R,
    input  in_ready, chk_valid, chk_col, chk_disp_L, chk_disp_R, chk_oob, row_done
  );

  modport slave (
    input  valid_final_L, valid_final_R, disp_L, disp_R,
    output in_ready, chk_valid, chk_col, chk_disp_L, chk_disp_R, chk_oob, row_done
  );

endinterface

// File: rtl/lrc_drain_pipe.sv
// Three-stage read pipeline: read L[x], then R[x - int(L[x])], present the pair.
module lrc_drain_pipe
  import lrc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [CWIDTH-1:0] w,
  input  logic [AWIDTH-1:0] range,
  input  logic [DWIDTH-1:0] q_L,
  input  logic [DWIDTH-1:0] q_R,
  output logic [AWIDTH-1:0] rd_addr_L,
  output logic [AWIDTH-1:0] rd_addr_R,
  output logic              chk_valid,
  output logic [AWIDTH-1:0] chk_col,
  output logic [DWIDTH-1:0] chk_disp_L,
  output logic [DWIDTH-1:0] chk_disp_R,
  output logic              chk_oob,
  output logic              last
);

  logic [CWIDTH-1:0]        x;
  logic                     issue;
  logic                     v1, v2;
  logic [AWIDTH-1:0]        x1, col2;
  logic [DWIDTH-1:0]        dl2;
  logic                     oob2, oob1;
  logic [IWIDTH-1:0]        d;
  logic signed [AWIDTH:0]   t;

  assign issue     = run && (x < w);
  assign rd_addr_L = issue ? x[AWIDTH-1:0] : '0;

  // Any d >= DEPTH is already out of range, so t only needs the low AWIDTH bits of d.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    rd_addr_R = '0;
    d         = disp_int(q_L);
    t         = $signed({1'b0, x1}) - $signed({1'b0, d[AWIDTH-1:0]});
    oob1      = t[AWIDTH] || (d >= IWIDTH'(range));
    if (v1 && !oob1) rd_addr_R = t[AWIDTH-1:0];
  end

  // Flush clears only the valid bits; stale data behind a cleared valid is harmless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x    <= '0;
      v1   <= 1'b0;
      v2   <= 1'b0;
      x1   <= '0;
      col2 <= '0;
      dl2  <= '0;
      oob2 <= 1'b0;
    end else if (!run) begin
      x  <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (issue) x <= x + CWIDTH'(1);
      v1 <= issue;
      x1 <= x[AWIDTH-1:0];
      v2 <= v1;
      if (v1) begin
        col2 <= x1;
        dl2  <= q_L;
        oob2 <= oob1;
      end
    end
  end

  assign chk_valid  = v2;
  assign chk_col    = col2;
  assign chk_disp_L = dl2;
  assign chk_disp_R = v2 ? q_R : '0;
  assign chk_oob    = oob2;
  assign last       = v2 && ({1'b0, col2} == w - CWIDTH'(1));

endmodule

// File: rtl/lrc_line_sched.sv
// Fill/drain sequencer for the left/right disparity line SRAMs feeding the LRC check.
module lrc_line_sched
  import lrc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [10:0]        width,
  input  logic [AWIDTH-1:0]  range,
  lrc_line_sched_if.slave    bus,
  output logic [AWIDTH-1:0]  wr_addr_lrc_L,
  output logic [AWIDTH-1:0]  wr_addr_lrc_R,
  output logic               wr_en_lrc_L,
  output logic               wr_en_lrc_R,
  output logic [AWIDTH-1:0]  rd_addr_lrc_L,
  output logic [AWIDTH-1:0]  rd_addr_lrc_R,
  input  logic [DWIDTH-1:0]  q_L,
  input  logic [DWIDTH-1:0]  q_R,
  output logic               err_width,
  output logic               err_ovf
);

  state_t            state;
  logic [CWIDTH-1:0] w, cnt_l, cnt_r, cnt_l_nxt, cnt_r_nxt;
  logic              acc_l, acc_r, ovf, width_ok, fill_done;
  logic              in_ready_q, row_done_q;
  logic              drain_run, last_pair;

  always_comb begin
    acc_l     = (state == FILL) && bus.valid_final_L && (cnt_l < w);
    acc_r     = (state == FILL) && bus.valid_final_R && (cnt_r < w);
    ovf       = (bus.valid_final_L && !acc_l) || (bus.valid_final_R && !acc_r);
    cnt_l_nxt = cnt_l + CWIDTH'(acc_l);
    cnt_r_nxt = cnt_r + CWIDTH'(acc_r);
    fill_done = (cnt_l_nxt == w) && (cnt_r_nxt == w);
    width_ok  = (width != '0) && (width <= 11'(DEPTH));
  end

  // Write strobes are combinational so the SRAM write lands in the strobe cycle.
  assign wr_en_lrc_L   = ~acc_l;
  assign wr_en_lrc_R   = ~acc_r;
  assign wr_addr_lrc_L = cnt_l[AWIDTH-1:0];
  assign wr_addr_lrc_R = cnt_r[AWIDTH-1:0];
  assign drain_run     = (state == DRAIN) && enable;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state      <= IDLE;
      w          <= '0;
      cnt_l      <= '0;
      cnt_r      <= '0;
      in_ready_q <= 1'b0;
      row_done_q <= 1'b0;
      err_width  <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      row_done_q <= 1'b0;
      if (ovf) err_ovf <= 1'b1;
      if (!enable) begin
        state      <= IDLE;
        in_ready_q <= 1'b0;
        cnt_l      <= '0;
        cnt_r      <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt_l <= '0;
            cnt_r <= '0;
            if (width_ok) begin
              w          <= width[CWIDTH-1:0];
              state      <= FILL;
              in_ready_q <= 1'b1;
            end else begin
              err_width <= 1'b1;
            end
          end
          FILL: begin
            cnt_l <= cnt_l_nxt;
            cnt_r <= cnt_r_nxt;
            if (fill_done) begin
              state      <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
          DRAIN: begin
            if (last_pair) begin
              row_done_q <= 1'b1;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.row_done = row_done_q;

  lrc_drain_pipe u_drain (
    .clk        (clk),
    .rst        (rst),
    .run        (drain_run),
    .w          (w),
    .range      (range),
    .q_L        (q_L),
    .q_R        (q_R),
    .rd_addr_L  (rd_addr_lrc_L),
    .rd_addr_R  (rd_addr_lrc_R),
    .chk_valid  (bus.chk_valid),
    .chk_col    (bus.chk_col),
    .chk_disp_L (bus.chk_disp_L),
    .chk_disp_R (bus.chk_disp_R),
    .chk_oob    (bus.chk_oob),
    .last       (last_pair)
  );

endmodule

// File: tb/tb_lrc_line_sched.sv
// Randomized scoreboard bench for lrc_line_sched with behavioural SRAMs and pair model.
module tb_lrc_line_sched;
  import lrc_pkg::*;

  typedef struct {
    int              col;
    logic [15:0]     dl;
    logic [15:0]     dr;
    bit              oob;
  } pair_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic [10:0]       width = '0;
  logic [AWIDTH-1:0] range_q = '0;
  logic [AWIDTH-1:0] wr_addr_L, wr_addr_R, rd_addr_L, rd_addr_R;
  logic              wr_en_L, wr_en_R, err_width, err_ovf;
  logic [DWIDTH-1:0] q_L = '0;
  logic [DWIDTH-1:0] q_R = '0;

  logic [DWIDTH-1:0] mem_l [DEPTH];
  logic [DWIDTH-1:0] mem_r [DEPTH];
  logic [DWIDTH-1:0] row_l [DEPTH];
  logic [DWIDTH-1:0] row_r [DEPTH];

  pair_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    done_exp = 1'b0;
  bit    found;

  lrc_line_sched_if bus();

  always #5 clk = ~clk;

  lrc_line_sched dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .width         (width),
    .range         (range_q),
    .bus           (bus),
    .wr_addr_lrc_L (wr_addr_L),
    .wr_addr_lrc_R (wr_addr_R),
    .wr_en_lrc_L   (wr_en_L),
    .wr_en_lrc_R   (wr_en_R),
    .rd_addr_lrc_L (rd_addr_L),
    .rd_addr_lrc_R (rd_addr_R),
    .q_L           (q_L),
    .q_R           (q_R),
    .err_width     (err_width),
    .err_ovf       (err_ovf)
  );

  // Behavioural single-port-per-direction SRAMs with one cycle read latency.
  always @(posedge clk) begin
    if (!wr_en_L) mem_l[wr_addr_L] <= bus.disp_L;
    if (!wr_en_R) mem_r[wr_addr_R] <= bus.disp_R;
    q_L <= mem_l[rd_addr_L];
    q_R <= mem_r[rd_addr_R];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected pair per chk_valid; row_done must follow the row's last pair.
  always @(negedge clk) begin : monitor
    pair_t p;
    if (bus.row_done || done_exp) check("row_done", 32'(bus.row_done), 32'(done_exp));
    done_exp = 1'b0;
    if (bus.chk_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pair", 32'(bus.chk_valid), 32'd0);
      end else begin
        p = exp_q.pop_front();
        check("chk_col",    32'(bus.chk_col),    32'(p.col));
        check("chk_disp_L", 32'(bus.chk_disp_L), 32'(p.dl));
        check("chk_disp_R", 32'(bus.chk_disp_R), 32'(p.dr));
        check("chk_oob",    32'(bus.chk_oob),    32'(p.oob));
        if (exp_q.size() == 0) done_exp = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pair x reads R at x - int(L[x]), or address 0 when out of bounds.
  function automatic void push_expected(input int w, input int rng);
    for (int x = 0; x < w; x++) begin
      int    d = int'(row_l[x]) / 16;
      int    t = x - d;
      pair_t p;
      p.oob = (t < 0) || (d >= rng);
      p.col = x;
      p.dl  = row_l[x];
      p.dr  = p.oob ? row_r[0] : row_r[t];
      exp_q.push_back(p);
    end
  endfunction

  task automatic gen_row(input int w, input int dmax);
    for (int i = 0; i < w; i++) begin
      row_l[i] = {12'($urandom_range(0, dmax)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 15) == 0) row_l[i][15:4] = 12'($urandom);
      row_r[i] = 16'($urandom);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    check({tag, "_wr_en_L"},   32'(wr_en_L),       32'd1);
    check({tag, "_wr_en_R"},   32'(wr_en_R),       32'd1);
    check({tag, "_rd_addr_L"}, 32'(rd_addr_L),     32'd0);
    check({tag, "_rd_addr_R"}, 32'(rd_addr_R),     32'd0);
    check({tag, "_chk_valid"}, 32'(bus.chk_valid), 32'd0);
    check({tag, "_chk_col"},   32'(bus.chk_col),   32'd0);
    check({tag, "_row_done"},  32'(bus.row_done),  32'd0);
    check({tag, "_err_width"}, 32'(err_width),     32'd0);
    check({tag, "_err_ovf"},   32'(err_ovf),       32'd0);
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at a negedge during DRAIN.
  task automatic fill_row(input int w, input int rng, input int lag_r, input int idle_pct,
                          input bit poke_drain);
    int il, ir, cyc, guard;
    bit vl, vr;
    width   = 11'(w);
    range_q = 9'(rng);
    enable  = 1'b1;
    guard   = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.in_ready && guard < 10);
    check("fill_start", 32'(bus.in_ready), 32'd1);
    tick();
    il = 0; ir = 0; cyc = 0;
    while ((il < w || ir < w) && cyc < 8000) begin
      vl = (il < w) && ($urandom_range(0, 99) >= idle_pct);
      vr = (ir < w) && (cyc >= lag_r) && ($urandom_range(0, 99) >= idle_pct);
      bus.valid_final_L = vl;
      bus.valid_final_R = vr;
      bus.disp_L = 16'($urandom);
      bus.disp_R = 16'($urandom);
      if (vl) bus.disp_L = row_l[il];
      if (vr) bus.disp_R = row_r[ir];
      @(negedge clk);
      if (vl) begin
        check("wr_en_L",   32'(wr_en_L),   32'd0);
        check("wr_addr_L", 32'(wr_addr_L), 32'(il));
        il++;
      end
      if (vr) begin
        check("wr_en_R",   32'(wr_en_R),   32'd0);
        check("wr_addr_R", 32'(wr_addr_R), 32'(ir));
        ir++;
      end
      if (vl || vr) check("in_ready_fill", 32'(bus.in_ready), 32'd1);
      tick();
      cyc++;
    end
    bus.valid_final_L = 1'b0;
    bus.valid_final_R = 1'b0;
    check("fill_count", 32'(il + ir), 32'(2 * w));
    push_expected(w, rng);
    if (poke_drain) begin
      bus.valid_final_L = 1'b1;
      bus.valid_final_R = 1'b1;
      @(negedge clk);
      check("poke_wr_en_L", 32'(wr_en_L), 32'd1);
      check("poke_wr_en_R", 32'(wr_en_R), 32'd1);
      check("in_ready_drop", 32'(bus.in_ready), 32'd0);
      tick();
      bus.valid_final_L = 1'b0;
      bus.valid_final_R = 1'b0;
      @(negedge clk);
      check("poke_err_ovf", 32'(err_ovf), 32'd1);
    end else begin
      @(negedge clk);
      check("in_ready_drop", 32'(bus.in_ready), 32'd0);
    end
  endtask

  // Waits for row_done, checks the refill turnaround, then parks the DUT in IDLE.
  task automatic finish_row(input int w);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.row_done && guard < w + 20);
    check("row_done_seen", 32'(bus.row_done), 32'd1);
    check("pairs_left", 32'(exp_q.size()), 32'd0);
    tick();
    @(negedge clk);
    check("refill_in_ready", 32'(bus.in_ready), 32'd1);
    enable = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_row(input int w, input int rng, input int lag_r, input int idle_pct,
                         input bit poke_drain);
    fill_row(w, rng, lag_r, idle_pct, poke_drain);
    finish_row(w);
  endtask

  task automatic wait_col(input int c, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(negedge clk);
      if (bus.chk_valid && bus.chk_col == AWIDTH'(c)) hit = 1'b1;
    end
    check("wait_col", 32'(hit), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int w;
    bus.valid_final_L = 1'b0;
    bus.valid_final_R = 1'b0;
    bus.disp_L = '0;
    bus.disp_R = '0;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    tick();
    rst = 1'b1;
    tick();

    // Aligned W=4: every column maps back onto R[0].
    for (int i = 0; i < 4; i++) begin
      row_l[i] = 16'(i << FRAC);
      row_r[i] = 16'(10 + i);
    end
    run_row(4, 64, 0, 0, 1'b0);

    // W=3 with the right stream five cycles behind the left.
    for (int i = 0; i < 3; i++) begin
      row_l[i] = 16'(i << FRAC);
      row_r[i] = 16'(20 + i);
    end
    run_row(3, 64, 5, 0, 1'b0);

    // Out-of-bounds cases: negative target and disparity at the range limit.
    row_l[0] = 16'(2 << FRAC);
    row_l[1] = 16'(0 << FRAC);
    row_l[2] = 16'(5 << FRAC);
    row_l[3] = 16'(1 << FRAC);
    for (int i = 0; i < 4; i++) row_r[i] = 16'(100 + i);
    run_row(4, 4, 0, 0, 1'b0);

    @(negedge clk);
    check("err_ovf_clean", 32'(err_ovf), 32'd0);
    check("err_width_clean", 32'(err_width), 32'd0);
    tick();

    // Strobes during DRAIN are dropped and flagged.
    gen_row(6, 8);
    run_row(6, 32, 0, 0, 1'b1);

    gen_row(1, 2);
    run_row(1, 16, 0, 0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      w = $urandom_range(1, 40);
      gen_row(w, w + 4);
      run_row(w, $urandom_range(1, 511), $urandom_range(0, 6), 30, 1'b0);
    end

    // Full depth row.
    gen_row(512, 600);
    run_row(512, 511, 3, 10, 1'b0);
    @(negedge clk);
    check("err_width_after_512", 32'(err_width), 32'd0);
    tick();

    // Zero width is rejected and the FSM stays in IDLE.
    width  = 11'd0;
    enable = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("width0_err", 32'(err_width), 32'd1);
    check("width0_idle", 32'(bus.in_ready), 32'd0);
    enable = 1'b0;
    tick();

    // Enable dropped mid-DRAIN: no further pairs or row_done, flags kept.
    gen_row(10, 12);
    fill_row(10, 64, 0, 0, 1'b0);
    wait_col(3, found);
    #1;
    enable = 1'b0;
    exp_q.delete();
    done_exp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_chk_valid", 32'(bus.chk_valid), 32'd0);
      check("abort_row_done",  32'(bus.row_done),  32'd0);
    end
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    check("abort_err_ovf_kept", 32'(err_ovf), 32'd1);
    check("abort_err_width_kept", 32'(err_width), 32'd1);
    tick();

    gen_row(7, 9);
    run_row(7, 64, 2, 20, 1'b0);

    // Asynchronous reset mid-DRAIN at column 7.
    gen_row(20, 24);
    fill_row(20, 128, 0, 0, 1'b0);
    wait_col(7, found);
    #1;
    rst = 1'b0;
    #1;
    check_reset_vals("midreset");
    exp_q.delete();
    done_exp = 1'b0;
    enable   = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Oversized width is rejected.
    width  = 11'd600;
    enable = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("width600_err", 32'(err_width), 32'd1);
    check("width600_idle", 32'(bus.in_ready), 32'd0);
    enable = 1'b0;
    tick();

    // After reset the next row restarts from column 0.
    gen_row(5, 6);
    run_row(5, 64, 1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
